// File: rtl/sram_line_packer.sv
// Packs four host words into one SRAM line and writes lines to consecutive addresses.
// Latency: wr_req rises 1 cycle after the 4th accepted word; in_ready returns 1 cycle after wr_ack.
// Backpressure: in_ready is low while a line waits for wr_ack; wr_addr/wr_data hold until acked.
module sram_line_packer #(
    parameter int               ADDRW     = 19,
    parameter int               DATAW     = 32,
    parameter logic [ADDRW-1:0] BASE_ADDR = '0,
    parameter logic [ADDRW-1:0] END_ADDR  = 19'h7FFFF
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [DATAW-1:0]   in_data,
    output logic               in_ready,
    output logic               wr_req,
    input  logic               wr_ack,
    output logic [ADDRW-1:0]   wr_addr,
    output logic [4*DATAW-1:0] wr_data,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              lane_cnt_q, lane_cnt_d;
    logic [ADDRW-1:0]        addr_q, addr_d;
    logic [3:0][DATAW-1:0]   lanes_q, lanes_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
            lanes_q    <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            addr_q     <= addr_d;
            lanes_q    <= lanes_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        addr_d     = addr_q;
        lanes_d    = lanes_q;
        case (state_q)
            IDLE, DONE: begin
                // start beats abort; lanes are cleared so a previous partial line never leaks out
                if (start) begin
                    state_d    = FILL;
                    lane_cnt_d = '0;
                    addr_d     = BASE_ADDR;
                    lanes_d    = '0;
                end else if (abort && state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (abort) begin
                    state_d    = IDLE;
                    lane_cnt_d = '0;
                end else if (in_valid) begin
                    lanes_d[lane_cnt_q] = in_data;
                    lane_cnt_d          = lane_cnt_q + 2'd1;
                    if (lane_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // >= rather than == so a BASE_ADDR above END_ADDR finishes instead of wrapping
                if (abort) begin
                    state_d = IDLE;
                end else if (wr_ack) begin
                    if (addr_q >= END_ADDR) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDRW'(1);
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == FILL);
    assign wr_req   = (state_q == WRITE);
    assign busy     = (state_q == FILL) || (state_q == WRITE);
    assign done     = (state_q == DONE);
    assign wr_addr  = addr_q;
    assign wr_data  = lanes_q;

endmodule

// File: doc/sram_line_packer.md
SRAM_LINE_PACKER -- requirements
Module: sram_line_packer

Interface
REQ-001 SHALL have parameter ADDRW, default 19, SRAM address width.
REQ-002 SHALL have parameter DATAW, default 32, input word width and per-chip data width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first line address written after start.
REQ-004 SHALL have parameter END_ADDR, default 19'h7FFFF, last line address written before done.
REQ-005 CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 RSTn  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse that begins a load.
REQ-008 abort  input  1  one-cycle pulse that cancels a load.
REQ-009 in_valid  input  1  host word valid.
REQ-010 in_data  input  DATAW  host word.
REQ-011 in_ready  output  1  packer accepts the word this cycle.
REQ-012 wr_req  output  1  line write request to the 4-chip SRAM write stage.
REQ-013 wr_ack  input  1  write stage has taken the line.
REQ-014 wr_addr  output  ADDRW  line address.
REQ-015 wr_data  output  4*DATAW  packed line; chip i uses bits [32i+31:32i].
REQ-016 busy  output  1  high in FILL or WRITE.
REQ-017 done  output  1  high in DONE.

Function
REQ-018 SHALL implement states IDLE, FILL, WRITE, DONE.
REQ-019 IDLE: start -> FILL; lane_cnt=0; addr=BASE_ADDR.
REQ-020 FILL: in_ready=1; each cycle with in_valid&in_ready stores in_data into lane[lane_cnt] and increments lane_cnt (2-bit).
REQ-021 The handshake that fills lane 3 SHALL move to WRITE on the next edge, with lane_cnt wrapping to 0.
REQ-022 WRITE: wr_req=1, in_ready=0; wr_addr and wr_data SHALL stay stable until wr_ack is sampled high.
REQ-023 WRITE with wr_ack=1 and addr==END_ADDR SHALL move to DONE; otherwise addr SHALL increment by 1 and the state SHALL return to FILL.
REQ-024 wr_ack SHALL be ignored outside WRITE.
REQ-025 Line latency SHALL be: wr_req asserts exactly 1 cycle after the 4th handshake; in_ready reasserts 1 cycle after the acked cycle.
REQ-026 DONE: done=1; start SHALL restart as in IDLE (done drops next cycle); in_ready=0.
REQ-027 start in FILL or WRITE SHALL be ignored.
REQ-028 abort in FILL or WRITE SHALL move to IDLE on the next edge; any partial line SHALL be discarded; wr_req and in_ready SHALL deassert.
REQ-029 abort and wr_ack in the same WRITE cycle: abort wins; addr SHALL NOT increment; done SHALL NOT assert.
REQ-030 abort and start in the same cycle in IDLE or DONE: start wins.
REQ-031 abort in IDLE or DONE SHALL have no effect except that abort in DONE returns to IDLE.
REQ-032 in_valid outside FILL SHALL be ignored; no word is consumed.
REQ-033 addr SHALL NOT wrap: with BASE_ADDR>END_ADDR, the first acked line SHALL go to DONE.
REQ-034 wr_data SHALL be registered; unused lanes after abort SHALL be cleared to 0 on the next start.

Reset
REQ-035 RSTn low SHALL immediately force IDLE, lane_cnt=0, addr=BASE_ADDR, lanes=0, in_ready=0, wr_req=0, busy=0, done=0, wr_addr=BASE_ADDR, wr_data=0.
REQ-036 Reset asserted mid-WRITE SHALL drop wr_req without waiting for wr_ack; after release the block SHALL wait in IDLE for start.

Verification
REQ-037 Basic line: BASE=0, END=1, start; words 11111111, 22222222, 33333333, 44444444 -> wr_req 1 cycle later, wr_addr=0, wr_data=4444444433333333222222221111111 1 (lane0 in LSBs).
REQ-038 Backpressure: hold wr_ack=0 for 5 cycles -> wr_req, wr_addr and wr_data stable and in_ready=0 throughout; ack -> addr=1, FILL.
REQ-039 Completion: END=1, two full lines acked -> done=1 after the second ack, busy=0; a further start -> addr=0 and FILL.
REQ-040 Abort: abort after 2 words -> IDLE next cycle, no wr_req; restart plus 4 words -> line at BASE_ADDR holding only the new words.
REQ-041 Collision: abort and wr_ack in the same cycle -> IDLE, done=0, addr unchanged.
REQ-042 Async reset: pull RSTn low between edges during WRITE -> wr_req=0 at once, before the next CLK edge.
